// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the single-cycle ARM subset control unit.
//   Op codes, data-processing cmd codes, ALUControl and ImmSrc codes,
//   condition codes and the RUN/HALT state enum.
package ctrl_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

endpackage

// File: rtl/arm_sc_controller_cond_unit.sv
// cond_unit: architectural NZCV flag register plus condition evaluation.
//   clock, reset_n     : clock, async active-low reset (flags clear to 0000)
//   cond               : instruction condition field
//   n, z, c, v         : main ALU flags for the current instruction
//   flag_w             : [1] load NZ, [0] load CV (requests before CondEx)
//   pcs, reg_w, mem_w  : ungated write requests from the decoder
//   write_en           : core is running and the instruction is defined
//   cond_ex            : condition holds against the registered flags
//   pc_src, reg_write, mem_write : write enables gated by cond_ex/write_en
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       write_en,
  output logic       cond_ex,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write
);

  logic n_q, z_q, c_q, v_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z_q;
      COND_NE: cond_ex = ~z_q;
      COND_CS: cond_ex = c_q;
      COND_CC: cond_ex = ~c_q;
      COND_MI: cond_ex = n_q;
      COND_PL: cond_ex = ~n_q;
      COND_VS: cond_ex = v_q;
      COND_VC: cond_ex = ~v_q;
      COND_HI: cond_ex = c_q & ~z_q;
      COND_LS: cond_ex = ~c_q | z_q;
      COND_GE: cond_ex = (n_q == v_q);
      COND_LT: cond_ex = (n_q != v_q);
      COND_GT: cond_ex = ~z_q & (n_q == v_q);
      COND_LE: cond_ex = z_q | (n_q != v_q);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;  // NV is undefined; the decoder halts on it
    endcase
  end

  assign pc_src    = pcs   & cond_ex & write_en;
  assign reg_write = reg_w & cond_ex & write_en;
  assign mem_write = mem_w & cond_ex & write_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else if (write_en && cond_ex) begin
      if (flag_w[1]) begin
        n_q <= n;
        z_q <= z;
      end
      if (flag_w[0]) begin
        c_q <= c;
        v_q <= v;
      end
    end
  end

endmodule

// File: rtl/arm_sc_controller.sv
// arm_sc_controller: control unit for the single-cycle ARM subset datapath.
//   Decodes Instr combinationally, gates all writes by the condition check
//   and the RUN/HALT state, and halts the core on an undefined instruction.
//   Inputs : clock, reset_n (async, active low), Instr, Z/N/C/V (ALU flags)
//   Outputs: PCSrc, RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite,
//            MemtoReg, PCEn, halted, undef, instret (retired count)
//   Build option: CTRL_PERF_EN implements the instret counter; without it
//   instret is tied to 0.
// Handshake: none; every output is valid in the same cycle as Instr, and
// state (flags, RUN/HALT, instret) advances on each rising clock edge.
module arm_sc_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      Instr,
  input  logic             Z,
  input  logic             N,
  input  logic             C,
  input  logic             V,
  output logic             PCSrc,
  output logic [1:0]       RegSrc,
  output logic             RegWrite,
  output logic [1:0]       ImmSrc,
  output logic             ALUSrc,
  output logic [1:0]       ALUControl,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             PCEn,
  output logic             halted,
  output logic             undef,
  output logic [CNT_W-1:0] instret
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign cmd   = funct[4:1];
  assign rd    = Instr[15:12];

  logic       reg_w, mem_w, branch, pcs, write_en, cond_ex, run;
  logic [1:0] flag_w;
  state_t     state, state_nx;

  // Main decoder. An undefined instruction drives every decode field to 0.
  always_comb begin
    RegSrc     = 2'b00;
    ImmSrc     = IMM_DP;
    ALUSrc     = 1'b0;
    ALUControl = ALU_ADD;
    MemtoReg   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    flag_w     = 2'b00;
    undef      = 1'b0;
    case (op)
      OP_DP: begin
        reg_w  = 1'b1;
        ALUSrc = funct[5];
        case (cmd)
          CMD_ADD: ALUControl = ALU_ADD;
          CMD_SUB: ALUControl = ALU_SUB;
          CMD_AND: ALUControl = ALU_AND;
          CMD_ORR: ALUControl = ALU_ORR;
          default: undef = 1'b1;
        endcase
        flag_w[1] = funct[0];
        flag_w[0] = funct[0] & ((cmd == CMD_ADD) | (cmd == CMD_SUB));
      end
      OP_MEM: begin
        ImmSrc = IMM_MEM;
        ALUSrc = 1'b1;
        if (funct[0]) begin
          MemtoReg = 1'b1;
          reg_w    = 1'b1;
        end else begin
          RegSrc = 2'b10;
          mem_w  = 1'b1;
        end
      end
      OP_BR: begin
        RegSrc = 2'b01;
        ImmSrc = IMM_BR;
        ALUSrc = 1'b1;
        branch = 1'b1;
      end
      default: undef = 1'b1;
    endcase
    if (cond == COND_NV) undef = 1'b1;
    if (undef) begin
      RegSrc     = 2'b00;
      ImmSrc     = IMM_DP;
      ALUSrc     = 1'b0;
      ALUControl = ALU_ADD;
      MemtoReg   = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      branch     = 1'b0;
      flag_w     = 2'b00;
    end
  end

  // A register write to R15 redirects the PC just like a branch.
  assign pcs = branch | (reg_w & (rd == 4'd15));

  // RUN/HALT state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_RUN;
    else          state <= state_nx;
  end

  // RUN/HALT next state: HALT is sticky until reset
  always_comb begin
    state_nx = state;
    if (state == S_RUN && undef) state_nx = S_HALT;
  end

  // RUN/HALT outputs; reset_n low forces every write enable off
  always_comb begin
    halted   = (state == S_HALT);
    run      = reset_n & (state == S_RUN);
    PCEn     = run & ~undef;
    write_en = run & ~undef;
  end

  cond_unit u_cond_unit (
    .clock     (clock),
    .reset_n   (reset_n),
    .cond      (cond),
    .n         (N),
    .z         (Z),
    .c         (C),
    .v         (V),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .write_en  (write_en),
    .cond_ex   (cond_ex),
    .pc_src    (PCSrc),
    .reg_write (RegWrite),
    .mem_write (MemWrite)
  );

  // Register numbers and offsets belong to the datapath; cond_ex is already
  // folded into the gated enables.
  logic unused_bits;
  assign unused_bits = ^{Instr[19:16], Instr[11:0], cond_ex};

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] instret_q;
  // Counts every defined instruction seen in RUN, taken or not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     instret_q <= '0;
    else if (state == S_RUN && !undef) instret_q <= instret_q + CNT_W'(1);
  end
  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_arm_sc_controller.sv
// tb_arm_sc_controller: directed vector table, hand-written reset/halt
// sequences and randomized instructions checked against a mnemonic-level
// model of the control unit.
module tb_arm_sc_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] Instr;
  logic        Z, N, C, V;
  logic        PCSrc, RegWrite, ALUSrc, MemWrite, MemtoReg, PCEn, halted, undef;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic [31:0] instret;

  arm_sc_controller #(.CNT_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .Instr      (Instr),
    .Z          (Z),
    .N          (N),
    .C          (C),
    .V          (V),
    .PCSrc      (PCSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .PCEn       (PCEn),
    .halted     (halted),
    .undef      (undef),
    .instret    (instret)
  );

  // clock / reset
  always #5 clock = ~clock;

  // {PCSrc, RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg,
  //  PCEn, halted, undef}
  logic [13:0] word;
  assign word = {PCSrc, RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
                 MemWrite, MemtoReg, PCEn, halted, undef};

  int compared = 0;
  int mismatched = 0;
  logic [13:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3;
  localparam int K_STR = 4, K_LDR = 5, K_B = 6, K_UNDEF = 7;

  logic m_n, m_z, m_c, m_v, m_halt;
  int unsigned m_cnt;

  task automatic model_reset();
    {m_n, m_z, m_c, m_v} = 4'b0000;
    m_halt = 1'b0;
    m_cnt  = 0;
  endtask

  function automatic int classify(input logic [31:0] ins);
    logic [3:0] cmd;
    cmd = ins[24:21];
    if (ins[31:28] == 4'hF) return K_UNDEF;
    case (ins[27:26])
      2'b00: begin
        if (cmd == 4'd4)  return K_ADD;
        if (cmd == 4'd2)  return K_SUB;
        if (cmd == 4'd0)  return K_AND;
        if (cmd == 4'd12) return K_ORR;
        return K_UNDEF;
      end
      2'b01:   return ins[20] ? K_LDR : K_STR;
      2'b10:   return K_B;
      default: return K_UNDEF;
    endcase
  endfunction

  function automatic logic holds(input logic [3:0] cc);
    case (cc)
      4'h0: return m_z;
      4'h1: return !m_z;
      4'h2: return m_c;
      4'h3: return !m_c;
      4'h4: return m_n;
      4'h5: return !m_n;
      4'h6: return m_v;
      4'h7: return !m_v;
      4'h8: return m_c && !m_z;
      4'h9: return !m_c || m_z;
      4'hA: return m_n == m_v;
      4'hB: return m_n != m_v;
      4'hC: return !m_z && (m_n == m_v);
      4'hD: return m_z || (m_n != m_v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [13:0] model_ctrl(input logic [31:0] ins, input logic in_reset);
    int k;
    logic [1:0] rs, imm, alu;
    logic asrc, mtr, wreg, live, ok, redirect;
    k = classify(ins);
    rs = 2'b00; imm = 2'b00; alu = 2'b00; asrc = 0; mtr = 0; wreg = 0;
    if (k <= K_ORR) begin
      wreg = 1; asrc = ins[25]; alu = 2'(k);
    end else if (k == K_STR) begin
      rs = 2'b10; imm = 2'b01; asrc = 1;
    end else if (k == K_LDR) begin
      imm = 2'b01; asrc = 1; mtr = 1; wreg = 1;
    end else if (k == K_B) begin
      rs = 2'b01; imm = 2'b10; asrc = 1;
    end
    live = !in_reset && !m_halt && (k != K_UNDEF);
    ok = holds(ins[31:28]);
    redirect = (k == K_B) || (wreg && ins[15:12] == 4'd15);
    return {live && ok && redirect, rs, live && ok && wreg, imm, asrc, alu,
            live && ok && (k == K_STR), mtr, live, m_halt && !in_reset,
            k == K_UNDEF};
  endfunction

  // Architectural effect of the instruction at the coming clock edge.
  task automatic model_commit(input logic [31:0] ins, input logic [3:0] nzcv);
    int k;
    k = classify(ins);
    if (m_halt) return;
    if (k == K_UNDEF) begin
      m_halt = 1'b1;
      return;
    end
    m_cnt++;
    if (holds(ins[31:28]) && k <= K_ORR && ins[20]) begin
      m_n = nzcv[3];
      m_z = nzcv[2];
      if (k == K_ADD || k == K_SUB) begin
        m_c = nzcv[1];
        m_v = nzcv[0];
      end
    end
  endtask

  function automatic logic [31:0] exp_instret();
`ifdef CTRL_PERF_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] ins, input logic [3:0] nzcv);
    @(negedge clock);
    Instr = ins;
    {N, Z, C, V} = nzcv;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_ctrl", 32'(word), 32'(model_ctrl(Instr, 1'b1)));
    check("rst_instret", instret, 32'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    logic [3:0] cmds[4];
    int k;
    cmds = '{4'd4, 4'd2, 4'd0, 4'd12};
    ins = $urandom;
    ins[31:28] = ($urandom_range(0, 24) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    k = $urandom_range(0, 11);
    if (k <= 5) begin
      ins[27:26] = 2'b00;
      ins[24:21] = cmds[$urandom_range(0, 3)];
    end else if (k == 6) begin
      ins[27:26] = 2'b00;
    end else if (k <= 8) begin
      ins[27:26] = 2'b01;
    end else if (k <= 10) begin
      ins[27:26] = 2'b10;
    end else begin
      ins[27:26] = 2'b11;
    end
    if ($urandom_range(0, 5) == 0) ins[15:12] = 4'hF;
    return ins;
  endfunction

  function automatic logic [13:0] mk(input logic pcs, input logic [1:0] rs,
                                     input logic rw, input logic [1:0] imm,
                                     input logic asrc, input logic [1:0] alu,
                                     input logic mw, input logic mtr);
    return {pcs, rs, rw, imm, asrc, alu, mw, mtr, 1'b1, 1'b0, 1'b0};
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  nzcv;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [31:0] frozen;
    logic [31:0] ins;
    logic [3:0]  nzcv;

    tbl[0]  = '{32'hE0921003, 4'b0110, mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0)}; // ADDS
    tbl[1]  = '{32'h0A000004, 4'b0000, mk(1, 2'b01, 0, 2'b10, 1, 2'b00, 0, 0)}; // BEQ taken
    tbl[2]  = '{32'hE0421003, 4'b0000, mk(0, 2'b00, 1, 2'b00, 0, 2'b01, 0, 0)}; // SUB
    tbl[3]  = '{32'h1A000004, 4'b0000, mk(0, 2'b01, 0, 2'b10, 1, 2'b00, 0, 0)}; // BNE not taken
    tbl[4]  = '{32'hE5821004, 4'b0000, mk(0, 2'b10, 0, 2'b01, 1, 2'b00, 1, 0)}; // STR
    tbl[5]  = '{32'hE5921000, 4'b0000, mk(0, 2'b00, 1, 2'b01, 1, 2'b00, 0, 1)}; // LDR
    tbl[6]  = '{32'hE082F003, 4'b0000, mk(1, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0)}; // ADD PC
    tbl[7]  = '{32'hE3921001, 4'b1001, mk(0, 2'b00, 1, 2'b00, 1, 2'b11, 0, 0)}; // ORRS imm
    tbl[8]  = '{32'hA0821003, 4'b0000, mk(0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0)}; // GE fails
    tbl[9]  = '{32'hB0821003, 4'b0000, mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0)}; // LT
    tbl[10] = '{32'h80821003, 4'b0000, mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0)}; // HI
    tbl[11] = '{32'h90821003, 4'b0000, mk(0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0)}; // LS fails
    tbl[12] = '{32'hE0021003, 4'b0000, mk(0, 2'b00, 1, 2'b00, 0, 2'b10, 0, 0)}; // AND
    tbl[13] = '{32'hE0521003, 4'b0000, mk(0, 2'b00, 1, 2'b00, 0, 2'b01, 0, 0)}; // SUBS -> 0000
    tbl[14] = '{32'h20821003, 4'b0000, mk(0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0)}; // CS fails
    tbl[15] = '{32'h00821003, 4'b0000, mk(0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0)}; // EQ fails
    tbl[16] = '{32'hD0821003, 4'b0000, mk(0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0)}; // LE fails
    tbl[17] = '{32'hC0821003, 4'b0000, mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0)}; // GT

    // reset held with a writing instruction present
    reset_n = 1'b0;
    Instr = 32'hE0821003;
    {N, Z, C, V} = 4'b0000;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_regwrite", 32'(RegWrite), 32'd0);
    check("reset_pcen", 32'(PCEn), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_instret", instret, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("release_regwrite", 32'(RegWrite), 32'd1);
    check("release_halted", 32'(halted), 32'd0);
    check("release_instret", instret, 32'd0);
    model_commit(Instr, 4'b0000);

    // directed vector table
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].instr, tbl[i].nzcv);
      check($sformatf("tbl_ctrl_%0d", i), 32'(word), 32'(tbl[i].exp));
      check($sformatf("tbl_instret_%0d", i), instret, exp_instret());
      model_commit(tbl[i].instr, tbl[i].nzcv);
    end

    // undefined op halts; nothing written by it or after it
    drive(32'hEC000000, 4'b0000);
    check("undef_ctrl", 32'(word), 32'h1);
    frozen = exp_instret();
    check("undef_instret", instret, frozen);
    model_commit(Instr, 4'b0000);
    drive(32'hE0821003, 4'b0000);
    check("halt_ctrl", 32'(word), 32'h2);
    check("halt_instret", instret, frozen);
    model_commit(Instr, 4'b0000);
    drive(32'hE5821004, 4'b0000);
    check("halt_memwrite", 32'(MemWrite), 32'd0);
    check("halt_instret2", instret, frozen);
    model_commit(Instr, 4'b0000);

    // reset in the middle of a flag-setting ADDS aborts it
    do_reset();
    drive(32'hE0921003, 4'b0110);
    check("abort_pre_regwrite", 32'(RegWrite), 32'd1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("abort_regwrite", 32'(RegWrite), 32'd0);
    check("abort_pcen", 32'(PCEn), 32'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    drive(32'h0A000004, 4'b0000);
    check("abort_beq_pcsrc", 32'(PCSrc), 32'd0);
    model_commit(Instr, 4'b0000);

    // condition NV is undefined and halts
    drive(32'hF0821003, 4'b0000);
    check("nv_undef", 32'(undef), 32'd1);
    check("nv_regwrite", 32'(RegWrite), 32'd0);
    model_commit(Instr, 4'b0000);
    drive(32'hE0821003, 4'b0000);
    check("nv_halted", 32'(halted), 32'd1);
    check("nv_pcen", 32'(PCEn), 32'd0);
    model_commit(Instr, 4'b0000);

    // randomized instructions against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_halt && $urandom_range(0, 2) == 0) do_reset();
      ins = gen_instr();
      nzcv = 4'($urandom_range(0, 15));
      drive(ins, nzcv);
      exp_q.push_back(model_ctrl(ins, 1'b0));
      check($sformatf("rnd_ctrl_%0d(%h)", i, ins), 32'(word), 32'(exp_q.pop_front()));
      check($sformatf("rnd_instret_%0d", i), instret, exp_instret());
      model_commit(ins, nzcv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
